// File: rtl/fft_bitrev_reorder_ctrl.sv
// Frame reorder controller: writes FFT samples into one of two SRAM banks in natural order
// and streams each completed bank back out in bit-reversed (or natural) order.
module fft_bitrev_reorder_ctrl #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 9,
  parameter int unsigned BitRev    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [DataWidth-1:0]      s_data_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [DataWidth-1:0]      m_data_o,
  output logic                      m_last_o,
  output logic                      mem_wen_o,
  output logic [1:0][AddrWidth:0]   mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  input  logic [DataWidth-1:0]      mem_rdata_i
);

  localparam logic [AddrWidth-1:0] LastIdx = '1;

  function automatic logic [AddrWidth-1:0] bitrev(input logic [AddrWidth-1:0] v);
    logic [AddrWidth-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AddrWidth); i++) r[i] = v[AddrWidth-1-i];
    return r;
  endfunction

  logic                 wr_bank, rd_bank;
  logic [AddrWidth-1:0] wcnt, rcnt, rd_idx;
  logic [1:0]           bank_full;
  logic                 rd_inflight, rd_last_q;
  logic [DataWidth-1:0] fifo_data [2];
  logic [1:0]           fifo_last;
  logic                 fifo_wptr, fifo_rptr;
  logic [1:0]           fifo_cnt;
  logic [2:0]           credit_used;
  logic                 wr_fire, pop, rd_en, wr_done, rd_done;

  assign s_ready_o   = !bank_full[wr_bank];
  assign wr_fire     = s_valid_i && s_ready_o;
  assign wr_done     = wr_fire && (wcnt == LastIdx);
  assign pop         = m_valid_o && m_ready_i;
  // Credit counts FIFO entries plus the read in flight, so the 2-entry FIFO can never overflow.
  assign credit_used = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_en       = bank_full[rd_bank] && (credit_used < 3'd2);
  assign rd_done     = rd_en && (rcnt == LastIdx);
  assign rd_idx      = (BitRev != 0) ? bitrev(rcnt) : rcnt;

  assign mem_wen_o   = wr_fire;
  assign mem_wdata_o = s_data_i;
  assign mem_addr_o  = {{wr_bank, wcnt}, {rd_bank, rd_idx}};

  assign m_valid_o   = (fifo_cnt != 2'd0);
  assign m_data_o    = fifo_data[fifo_rptr];
  assign m_last_o    = m_valid_o && fifo_last[fifo_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank <= 1'b0;
      wcnt    <= '0;
    end else if (wr_fire) begin
      wcnt <= wr_done ? '0 : wcnt + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_bank     <= 1'b0;
      rcnt        <= '0;
      rd_inflight <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      rd_inflight <= rd_en;
      if (rd_en) begin
        rd_last_q <= rd_done;
        rcnt      <= rd_done ? '0 : rcnt + 1'b1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  // The write and read sides always own different banks, so both flags may change together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_full <= 2'b00;
    end else begin
      if (wr_done) bank_full[wr_bank] <= 1'b1;
      if (rd_done) bank_full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last <= 2'b00;
      fifo_wptr <= 1'b0;
      fifo_rptr <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      if (rd_inflight) begin
        fifo_data[fifo_wptr] <= mem_rdata_i;
        fifo_last[fifo_wptr] <= rd_last_q;
        fifo_wptr            <= ~fifo_wptr;
      end
      if (pop) fifo_rptr <= ~fifo_rptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder_ctrl.sv
// Directed bench for fft_bitrev_reorder_ctrl with N=8: a bit-reversed instance plus a
// natural-order instance sharing stimulus, each backed by a 1-cycle-latency SRAM model.
module tb_fft_bitrev_reorder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, m_ready;
  logic [8:0] s_data;

  logic       s_ready, m_valid, m_last, mem_wen;
  logic [8:0] m_data, mem_wdata, mem_rdata;
  logic [1:0][3:0] mem_addr;

  logic       n_s_ready, n_m_valid, n_m_last, n_mem_wen;
  logic [8:0] n_m_data, n_mem_wdata, n_mem_rdata;
  logic [1:0][3:0] n_mem_addr;

  logic [8:0] sram_b [16];
  logic [8:0] sram_n [16];

  int checks = 0;
  int errors = 0;
  int brv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft_bitrev_reorder_ctrl #(.AddrWidth(3), .DataWidth(9), .BitRev(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  fft_bitrev_reorder_ctrl #(.AddrWidth(3), .DataWidth(9), .BitRev(0)) dut_nat (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(n_s_ready), .s_data_i(s_data),
    .m_valid_o(n_m_valid), .m_ready_i(m_ready), .m_data_o(n_m_data), .m_last_o(n_m_last),
    .mem_wen_o(n_mem_wen), .mem_addr_o(n_mem_addr), .mem_wdata_o(n_mem_wdata),
    .mem_rdata_i(n_mem_rdata)
  );

  // SRAM models: registered read, one cycle after the read address edge.
  always @(posedge clk) begin
    if (mem_wen) sram_b[mem_addr[1]] <= mem_wdata;
    mem_rdata <= sram_b[mem_addr[0]];
    if (n_mem_wen) sram_n[n_mem_addr[1]] <= n_mem_wdata;
    n_mem_rdata <= sram_n[n_mem_addr[0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] d, input logic r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 9'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  // Streams inputs base+sent.. and scoreboards outputs in per-frame bit-reversed order.
  task automatic run_stream(input int sent0, input int total, input int base,
                            input int vp, input int rp, input bit strict, input int budget);
    int  sent    = sent0;
    int  got     = 0;
    int  cyc     = 0;
    bit  started = 1'b0;
    int  exp_val;
    while (got < total && cyc < budget) begin
      applyStimulus((sent < total) && ($urandom_range(99) < vp), 9'(base + sent),
                    $urandom_range(99) < rp);
      if (strict && sent < total) checkOutput("stream_s_ready", 32'(s_ready), 32'd1);
      if (strict && started)      checkOutput("stream_no_gap", 32'(m_valid), 32'd1);
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) begin
        exp_val = base + (got / 8) * 8 + brv[got % 8];
        checkOutput("stream_data", 32'(m_data), 32'(exp_val));
        checkOutput("stream_last", 32'(m_last), 32'((got % 8) == 7));
        got++;
        started = 1'b1;
      end
      tick();
      cyc++;
    end
    checkOutput("stream_outputs_done", 32'(got), 32'(total));
  endtask

  initial begin
    int acc;
    rst_n = 1'b0;
    applyStimulus(1'b0, 9'd0, 1'b0);

    // Reset values, held while reset is asserted.
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single frame 0..7, both orders, with latency from the last accept.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 9'(i), 1'b1);
      checkOutput("wr_wen", 32'(mem_wen), 32'd1);
      checkOutput("wr_addr", 32'(mem_addr[1]), 32'(i));
      checkOutput("wr_wdata", 32'(mem_wdata), 32'(i));
      tick();
    end
    applyStimulus(1'b0, 9'h1AA, 1'b1);
    checkOutput("idle_wen", 32'(mem_wen), 32'd0);
    checkOutput("lat_e0_valid", 32'(m_valid), 32'd0);
    tick();
    checkOutput("lat_e1_valid", 32'(m_valid), 32'd0);
    tick();
    for (int j = 0; j < 8; j++) begin
      checkOutput("single_valid", 32'(m_valid), 32'd1);
      checkOutput("single_data", 32'(m_data), 32'(brv[j]));
      checkOutput("single_last", 32'(m_last), 32'(j == 7));
      checkOutput("nat_valid", 32'(n_m_valid), 32'd1);
      checkOutput("nat_data", 32'(n_m_data), 32'(j));
      checkOutput("nat_last", 32'(n_m_last), 32'(j == 7));
      tick();
    end
    checkOutput("single_end_valid", 32'(m_valid), 32'd0);

    // Four back-to-back frames at full rate.
    applyReset();
    run_stream(0, 32, 0, 100, 100, 1'b1, 200);

    // Output stalled while three frames are offered.
    applyReset();
    acc = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b1, 9'(acc), 1'b0);
      checkOutput("stall_s_ready", 32'(s_ready), 32'(acc < 16));
      if (c >= 10) begin
        checkOutput("stall_valid", 32'(m_valid), 32'd1);
        checkOutput("stall_data_hold", 32'(m_data), 32'd0);
      end
      if (s_valid && s_ready) acc++;
      tick();
    end
    checkOutput("stall_accepted", 32'(acc), 32'd16);
    run_stream(16, 24, 0, 100, 100, 1'b0, 300);

    // Random handshakes over 20 frames.
    applyReset();
    run_stream(0, 160, 300, 50, 50, 1'b0, 5000);

    // Reset in the middle of the second frame with output buffered.
    applyReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 9'(50 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 9'd0, 1'b0);
    checkOutput("pre_rst_valid", 32'(m_valid), 32'd1);
    checkOutput("pre_rst_data", 32'(m_data), 32'd50);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("async_rst_last", 32'(m_last), 32'd0);
    checkOutput("async_rst_data", 32'(m_data), 32'd0);
    checkOutput("async_rst_wen", 32'(mem_wen), 32'd0);
    checkOutput("async_rst_s_ready", 32'(s_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    run_stream(0, 8, 100, 100, 100, 1'b1, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
